// File: rtl/mmio_port_bank_pkg.sv
// Shared defaults and address-map helpers for the MMIO port bank.
// Memory-side decoders import the same package so both views of the map agree.
package mmio_port_bank_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_N_PORTS = 16;
    localparam int MAX_PORTS   = 16;

    localparam logic [7:0] DEF_OUT_BASE = 8'hE0;
    localparam logic [7:0] DEF_IN_BASE  = 8'hF0;
    localparam logic [7:0] DEF_CHG_BASE = 8'hD0;

    // Cycles after reset before input changes may raise a flag.
    localparam int WARM_CYCLES = 2;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_OUT,
        REG_IN,
        REG_CHG
    } region_e;

    function automatic logic addr_match(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int          idx);
        return addr == base + 32'(idx);
    endfunction

    function automatic logic ranges_overlap(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          n);
        return (a < b + 32'(n)) && (b < a + 32'(n));
    endfunction

endpackage

// File: rtl/mmio_port_bank_chg_detect.sv
// One input lane: two-stage input capture plus a sticky change flag.
// A set and a clear in the same cycle leave the flag set.
module mmio_chg_detect
    import mmio_port_bank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pin,
    input  logic              set_en,
    input  logic              clr,
    output logic [DATA_W-1:0] in_q,
    output logic              flag
);

    logic [DATA_W-1:0] in_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_q    <= '0;
            in_prev <= '0;
            flag    <= 1'b0;
        end else begin
            in_q    <= pin;
            in_prev <= in_q;
            if (set_en && (in_q != in_prev)) begin
                flag <= 1'b1;
            end else if (clr) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mmio_port_bank.sv
// Parametrised memory-mapped I/O port bank with per-input change flags.
// Optional interrupt request enabled by defining MMIO_IRQ_EN.
module mmio_port_bank
    import mmio_port_bank_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                N_PORTS  = DEF_N_PORTS,
    parameter logic [ADDR_W-1:0] OUT_BASE = ADDR_W'(DEF_OUT_BASE),
    parameter logic [ADDR_W-1:0] IN_BASE  = ADDR_W'(DEF_IN_BASE),
    parameter logic [ADDR_W-1:0] CHG_BASE = ADDR_W'(DEF_CHG_BASE)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         address,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      write,
    input  logic [N_PORTS*DATA_W-1:0] port_in,
    output logic [N_PORTS*DATA_W-1:0] port_out,
    output logic [DATA_W-1:0]         data_out,
    output logic                      rd_hit,
    output logic                      irq
);

    if (N_PORTS < 1 || N_PORTS > MAX_PORTS) begin : g_bad_n_ports
        $error("mmio_port_bank: N_PORTS must be 1..16");
    end
    if (ranges_overlap(32'(OUT_BASE), 32'(IN_BASE), N_PORTS) ||
        ranges_overlap(32'(OUT_BASE), 32'(CHG_BASE), N_PORTS) ||
        ranges_overlap(32'(IN_BASE), 32'(CHG_BASE), N_PORTS)) begin : g_bad_map
        $error("mmio_port_bank: OUT/IN/CHG address ranges overlap");
    end

    logic [DATA_W-1:0]  port_out_r [N_PORTS];
    logic [DATA_W-1:0]  in_q       [N_PORTS];
    logic [N_PORTS-1:0] flag;
    logic [N_PORTS-1:0] out_sel;
    logic [N_PORTS-1:0] in_sel;
    logic [N_PORTS-1:0] chg_sel;
    logic [1:0]         warm;
    region_e            region;
    logic [DATA_W-1:0]  rd_data_p0;
    logic [DATA_W-1:0]  data_out_p1;
    logic               rd_hit_p1;

    // Stage p0: address decode and read mux over current state.
    always_comb begin
        out_sel = '0;
        in_sel  = '0;
        chg_sel = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            out_sel[i] = addr_match(32'(address), 32'(OUT_BASE), i);
            in_sel[i]  = addr_match(32'(address), 32'(IN_BASE), i);
            chg_sel[i] = addr_match(32'(address), 32'(CHG_BASE), i);
        end
    end

    always_comb begin
        region = REG_NONE;
        if (|out_sel) begin
            region = REG_OUT;
        end else if (|in_sel) begin
            region = REG_IN;
        end else if (|chg_sel) begin
            region = REG_CHG;
        end
    end

    always_comb begin
        rd_data_p0 = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            case (region)
                REG_OUT: if (out_sel[i]) rd_data_p0 = port_out_r[i];
                REG_IN:  if (in_sel[i])  rd_data_p0 = in_q[i];
                REG_CHG: if (chg_sel[i]) rd_data_p0 = DATA_W'(flag[i]);
                default: ;
            endcase
        end
    end

    // Stage p1: registered read data and output ports.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_p1 <= '0;
            rd_hit_p1   <= 1'b0;
        end else begin
            data_out_p1 <= rd_data_p0;
            rd_hit_p1   <= (region != REG_NONE);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_PORTS; i++) begin
            if (reset) begin
                port_out_r[i] <= '0;
            end else if (write && out_sel[i]) begin
                port_out_r[i] <= data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            warm <= 2'(WARM_CYCLES);
        end else if (warm != 2'd0) begin
            warm <= warm - 2'd1;
        end
    end

    for (genvar g = 0; g < N_PORTS; g++) begin : g_lane
        mmio_chg_detect #(
            .DATA_W(DATA_W)
        ) u_chg (
            .clk   (clk),
            .reset (reset),
            .pin   (port_in[g*DATA_W +: DATA_W]),
            .set_en(warm == 2'd0),
            .clr   (write && chg_sel[g]),
            .in_q  (in_q[g]),
            .flag  (flag[g])
        );
        assign port_out[g*DATA_W +: DATA_W] = port_out_r[g];
    end

    assign data_out = data_out_p1;
    assign rd_hit   = rd_hit_p1;

`ifdef MMIO_IRQ_EN
    logic irq_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_p1 <= 1'b0;
        end else begin
            irq_p1 <= |flag;
        end
    end

    assign irq = irq_p1;
`else
    assign irq = 1'b0;
`endif

endmodule
